adder_tree_layer: RTL and testbench
===================================

ADDER_TREE_LAYER -- requirements
Module: adder_tree_layer

Interface
REQ-001 Parameters SHALL be as follows, one per line (name, default, meaning):
- NUM_IN_WORDS, 5, number of input words.
- BITS_PER_IN_WORD, 13, width of each input word.
- BITS_PER_OUT_WORD, 15, width of each output word.
- SIGN_EXT, 1, 1 = sign-extend operands, 0 = zero-extend.
- REGISTER_MIDDLE, 0, 1 = pipeline register inside each adder.
- REGISTER_OUTPUT, 1, 1 = register the output words.
- SHIFT, 1, left shift applied to the odd word of each pair.
- EXTRA_BIT_CONNECTED, 0, 1 = pipeline extra_bit_in to extra_bit_out.
REQ-002 Derived constant NUM_OUT_WORDS SHALL equal NUM_IN_WORDS/2 + NUM_IN_WORDS%2 (integer division).
REQ-003 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, all registers rising-edge.
- rst, in, 1, reset, synchronous, active-high.
- in_words, in, NUM_IN_WORDS*BITS_PER_IN_WORD, packed input words; word k occupies bits [k*BITS_PER_IN_WORD +: BITS_PER_IN_WORD].
- out_words, out, NUM_OUT_WORDS*BITS_PER_OUT_WORD, packed output words; word 0 is in the LSBs.
- extra_bit_in, in, 1, sideband bit travelling with the data.
- extra_bit_out, out, 1, delayed sideband bit.

Function
REQ-004 Each input word SHALL be extended to BITS_PER_OUT_WORD: sign-extended when SIGN_EXT=1, zero-extended when SIGN_EXT=0.
REQ-005 For i < NUM_IN_WORDS/2, out word i SHALL equal ext(in[2i]) + (ext(in[2i+1]) << SHIFT), computed modulo 2^BITS_PER_OUT_WORD; shifted-in LSBs are 0 and overflow bits are discarded.
REQ-006 If NUM_IN_WORDS is odd, the last output word SHALL equal ext(in[NUM_IN_WORDS-1]), unshifted, delayed by the same latency as the sums.
REQ-007 Latency from in_words to out_words SHALL be REGISTER_MIDDLE + REGISTER_OUTPUT cycles; when this is 0 the path is purely combinational.
REQ-008 With REGISTER_MIDDLE=1, the lower floor(BITS_PER_OUT_WORD/2) bits of each sum SHALL be added in stage 1.
REQ-009 With REGISTER_MIDDLE=1, the stage-1 carry, the lower sum bits and the upper operand bits SHALL be registered, and the upper half SHALL be added in stage 2.
REQ-010 The REGISTER_MIDDLE=1 result SHALL be bit-identical to the REGISTER_MIDDLE=0 result, only delayed.
REQ-011 With EXTRA_BIT_CONNECTED=1, extra_bit_out SHALL equal extra_bit_in delayed by exactly the data latency.
REQ-012 With EXTRA_BIT_CONNECTED=0, extra_bit_out SHALL be constant 0.
REQ-013 The block SHALL have no handshake; one new set of words is accepted every cycle (full throughput).
REQ-014 BITS_PER_OUT_WORD >= BITS_PER_IN_WORD and NUM_IN_WORDS >= 2 are required parameter values.

Reset
REQ-015 While rst=1 at a clk edge, all pipeline registers, including the extra-bit delay line, SHALL clear to 0.
REQ-016 With registered paths, out_words=0 and extra_bit_out=0 SHALL hold during the cycles following reset.
REQ-017 Purely combinational paths SHALL be unaffected by rst.
REQ-018 Reset asserted mid-stream SHALL discard all in-flight data; valid outputs resume after the configured latency once rst is deasserted.

Configuration
REQ-019 When macro ADDER_TREE_LAYER_PARAM_CHECK_EN is defined, elaboration/simulation SHALL check REQ-014.
REQ-020 On a violation with ADDER_TREE_LAYER_PARAM_CHECK_EN defined, the block SHALL print an error message and call $stop.
REQ-021 Without ADDER_TREE_LAYER_PARAM_CHECK_EN, no check code SHALL be compiled and behaviour is otherwise identical.

Verification
REQ-022 Defaults, in words {0,0,0,5,3} (word0=3, word1=5) -> out word0=13 one cycle later.
REQ-023 SIGN_EXT=1, word0=0x1FFF, word1=0x0001 -> out word0=0x0001; with SIGN_EXT=0 -> out word0=0x2001.
REQ-024 Odd word4=0x1000 -> out word2=0x7000 with SIGN_EXT=1, 0x1000 with SIGN_EXT=0.
REQ-025 REGISTER_MIDDLE=1, REGISTER_OUTPUT=1, EXTRA_BIT_CONNECTED=1, random words streamed every cycle -> outputs match the REQ-005 model exactly 2 cycles later, and extra_bit_out tracks extra_bit_in with a 2-cycle delay.
REQ-026 Overflow case word0=0x0FFF, word1=0x0FFF, BITS_PER_OUT_WORD=13, SHIFT=1, SIGN_EXT=0 -> out word0=0x0FFD (truncated).
REQ-027 Assert rst for 1 cycle mid-stream -> out_words=0 and extra_bit_out=0 on the next cycle, then correct sums resume.

Source files
------------

// File: rtl/adder_tree_layer.sv
`default_nettype none
// ============================================================================
// Module   : adder_tree_layer
// Purpose  : One adder-tree layer. Adds word pairs (odd word shifted left) and
//            passes a trailing odd word through. Optional middle and output
//            pipeline stages. Optional sideband bit delay line.
//            Define ADDER_TREE_LAYER_PARAM_CHECK_EN to enable parameter checks.
// Revision : 1.0 - initial release
// ============================================================================
module adder_tree_layer #(
    parameter int NUM_IN_WORDS        = 5,
    parameter int BITS_PER_IN_WORD    = 13,
    parameter int BITS_PER_OUT_WORD   = 15,
    parameter int SIGN_EXT            = 1,
    parameter int REGISTER_MIDDLE     = 0,
    parameter int REGISTER_OUTPUT     = 1,
    parameter int SHIFT               = 1,
    parameter int EXTRA_BIT_CONNECTED = 0,
    localparam int NUM_OUT_WORDS      = NUM_IN_WORDS / 2 + NUM_IN_WORDS % 2
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_IN_WORDS*BITS_PER_IN_WORD-1:0]    in_words,
    output logic [NUM_OUT_WORDS*BITS_PER_OUT_WORD-1:0]  out_words,
    input  logic                                        extra_bit_in,
    output logic                                        extra_bit_out
);

    localparam int c_NUM_PAIRS = NUM_IN_WORDS / 2;
    localparam int c_LATENCY   = REGISTER_MIDDLE + REGISTER_OUTPUT;
    localparam int c_LO_BITS   = BITS_PER_OUT_WORD / 2;
    localparam int c_HI_BITS   = BITS_PER_OUT_WORD - c_LO_BITS;

    logic [BITS_PER_OUT_WORD-1:0]               w_ext [NUM_IN_WORDS];
    logic [NUM_OUT_WORDS*BITS_PER_OUT_WORD-1:0] w_mid;
    logic                                       w_unused_inputs;

    // Some configurations leave rst or extra_bit_in without a load.
    assign w_unused_inputs = ^{extra_bit_in, rst};

    for (genvar k = 0; k < NUM_IN_WORDS; k++) begin : g_ext
        if (SIGN_EXT != 0) begin : g_sign
            assign w_ext[k] = BITS_PER_OUT_WORD'($signed(in_words[k*BITS_PER_IN_WORD +: BITS_PER_IN_WORD]));
        end else begin : g_zero
            assign w_ext[k] = BITS_PER_OUT_WORD'(in_words[k*BITS_PER_IN_WORD +: BITS_PER_IN_WORD]);
        end
    end

    for (genvar i = 0; i < c_NUM_PAIRS; i++) begin : g_pair
        logic [BITS_PER_OUT_WORD-1:0] w_a;
        logic [BITS_PER_OUT_WORD-1:0] w_b;

        assign w_a = w_ext[2*i];
        assign w_b = w_ext[2*i+1] << SHIFT;

        if (REGISTER_MIDDLE != 0) begin : g_split
            logic [c_LO_BITS:0]   w_lo_sum;
            logic [c_HI_BITS-1:0] w_hi_sum;
            logic [c_LO_BITS-1:0] r_lo;
            logic                 r_carry;
            logic [c_HI_BITS-1:0] r_hi_a;
            logic [c_HI_BITS-1:0] r_hi_b;

            assign w_lo_sum = {1'b0, w_a[c_LO_BITS-1:0]} + {1'b0, w_b[c_LO_BITS-1:0]};

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_lo    <= '0;
                    r_carry <= 1'b0;
                    r_hi_a  <= '0;
                    r_hi_b  <= '0;
                end else begin
                    r_lo    <= w_lo_sum[c_LO_BITS-1:0];
                    r_carry <= w_lo_sum[c_LO_BITS];
                    r_hi_a  <= w_a[BITS_PER_OUT_WORD-1:c_LO_BITS];
                    r_hi_b  <= w_b[BITS_PER_OUT_WORD-1:c_LO_BITS];
                end
            end

            // Upper half completes the sum; carry-out of the top bit is dropped.
            assign w_hi_sum = r_hi_a + r_hi_b + c_HI_BITS'(r_carry);
            assign w_mid[i*BITS_PER_OUT_WORD +: BITS_PER_OUT_WORD] = {w_hi_sum, r_lo};
        end else begin : g_direct
            assign w_mid[i*BITS_PER_OUT_WORD +: BITS_PER_OUT_WORD] = w_a + w_b;
        end
    end

    if (NUM_IN_WORDS % 2 != 0) begin : g_odd
        if (REGISTER_MIDDLE != 0) begin : g_odd_reg
            logic [BITS_PER_OUT_WORD-1:0] r_odd;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_odd <= '0;
                end else begin
                    r_odd <= w_ext[NUM_IN_WORDS-1];
                end
            end

            assign w_mid[c_NUM_PAIRS*BITS_PER_OUT_WORD +: BITS_PER_OUT_WORD] = r_odd;
        end else begin : g_odd_direct
            assign w_mid[c_NUM_PAIRS*BITS_PER_OUT_WORD +: BITS_PER_OUT_WORD] = w_ext[NUM_IN_WORDS-1];
        end
    end

    if (REGISTER_OUTPUT != 0) begin : g_out_reg
        logic [NUM_OUT_WORDS*BITS_PER_OUT_WORD-1:0] r_out;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_out <= '0;
            end else begin
                r_out <= w_mid;
            end
        end

        assign out_words = r_out;
    end else begin : g_out_comb
        assign out_words = w_mid;
    end

    if ((EXTRA_BIT_CONNECTED != 0) && (c_LATENCY > 0)) begin : g_extra_pipe
        logic [c_LATENCY-1:0] r_extra;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_extra <= '0;
            end else begin
                r_extra <= (r_extra << 1) | c_LATENCY'(extra_bit_in);
            end
        end

        assign extra_bit_out = r_extra[c_LATENCY-1];
    end else if (EXTRA_BIT_CONNECTED != 0) begin : g_extra_comb
        assign extra_bit_out = extra_bit_in;
    end else begin : g_extra_off
        assign extra_bit_out = 1'b0;
    end

`ifdef ADDER_TREE_LAYER_PARAM_CHECK_EN
    if ((BITS_PER_OUT_WORD < BITS_PER_IN_WORD) || (NUM_IN_WORDS < 2)) begin : g_param_check
        always @(posedge clk) begin
            $error("adder_tree_layer: illegal parameters NUM_IN_WORDS=%0d BITS_PER_IN_WORD=%0d BITS_PER_OUT_WORD=%0d",
                   NUM_IN_WORDS, BITS_PER_IN_WORD, BITS_PER_OUT_WORD);
            $stop;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_tree_layer.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_tree_layer
// Purpose  : Directed vector bench for adder_tree_layer in five configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_tree_layer;

    localparam int c_N = 13;

    logic        clk          = 1'b0;
    logic        rst          = 1'b1;
    logic [64:0] in_words     = '0;
    logic        extra_bit_in = 1'b0;

    logic [44:0] out0, out1, out2, out4;
    logic [38:0] out3;
    logic        xb0, xb1, xb2, xb3, xb4;

    int checks = 0;
    int errors = 0;

    logic [64:0] vin     [6];
    logic [44:0] exp_se1 [6];
    logic [44:0] exp_se0 [6];
    logic [38:0] exp_n13 [6];
    int          sched_idx [c_N];
    logic        sched_rst [c_N];
    logic        sched_eb  [c_N];

    // defaults: sign-extend, output register only
    adder_tree_layer u_dut0 (
        .clk(clk), .rst(rst), .in_words(in_words), .out_words(out0),
        .extra_bit_in(extra_bit_in), .extra_bit_out(xb0));

    adder_tree_layer #(.SIGN_EXT(0)) u_dut1 (
        .clk(clk), .rst(rst), .in_words(in_words), .out_words(out1),
        .extra_bit_in(extra_bit_in), .extra_bit_out(xb1));

    adder_tree_layer #(.REGISTER_MIDDLE(1), .REGISTER_OUTPUT(1), .EXTRA_BIT_CONNECTED(1)) u_dut2 (
        .clk(clk), .rst(rst), .in_words(in_words), .out_words(out2),
        .extra_bit_in(extra_bit_in), .extra_bit_out(xb2));

    adder_tree_layer #(.BITS_PER_OUT_WORD(13), .SIGN_EXT(0)) u_dut3 (
        .clk(clk), .rst(rst), .in_words(in_words), .out_words(out3),
        .extra_bit_in(extra_bit_in), .extra_bit_out(xb3));

    adder_tree_layer #(.REGISTER_MIDDLE(0), .REGISTER_OUTPUT(0), .EXTRA_BIT_CONNECTED(1)) u_dut4 (
        .clk(clk), .rst(rst), .in_words(in_words), .out_words(out4),
        .extra_bit_in(extra_bit_in), .extra_bit_out(xb4));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int idx_at(input int j);
        return (j < c_N) ? sched_idx[j] : 5;
    endfunction

    function automatic logic rst_at(input int j);
        return (j < c_N) ? sched_rst[j] : 1'b0;
    endfunction

    function automatic logic eb_at(input int j);
        return (j < c_N) ? sched_eb[j] : 1'b0;
    endfunction

    initial begin
        // words listed w4..w0
        vin[0] = {13'h0000, 13'h0000, 13'h0000, 13'h0005, 13'h0003};
        vin[1] = {13'h0000, 13'h0000, 13'h0000, 13'h0001, 13'h1FFF};
        vin[2] = {13'h1000, 13'h0F00, 13'h0123, 13'h1800, 13'h0800};
        vin[3] = {13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF};
        vin[4] = {13'h0001, 13'h0555, 13'h0AAA, 13'h0FFF, 13'h0FFF};
        vin[5] = '0;

        // out words listed o2, o1, o0
        exp_se1[0] = {15'h0000, 15'h0000, 15'h000D};
        exp_se1[1] = {15'h0000, 15'h0000, 15'h0001};
        exp_se1[2] = {15'h7000, 15'h1F23, 15'h7800};
        exp_se1[3] = {15'h7FFF, 15'h7FFD, 15'h7FFD};
        exp_se1[4] = {15'h0001, 15'h1554, 15'h2FFD};
        exp_se1[5] = '0;

        exp_se0[0] = {15'h0000, 15'h0000, 15'h000D};
        exp_se0[1] = {15'h0000, 15'h0000, 15'h2001};
        exp_se0[2] = {15'h1000, 15'h1F23, 15'h3800};
        exp_se0[3] = {15'h1FFF, 15'h5FFD, 15'h5FFD};
        exp_se0[4] = {15'h0001, 15'h1554, 15'h2FFD};
        exp_se0[5] = '0;

        exp_n13[0] = {13'h0000, 13'h0000, 13'h000D};
        exp_n13[1] = {13'h0000, 13'h0000, 13'h0001};
        exp_n13[2] = {13'h1000, 13'h1F23, 13'h1800};
        exp_n13[3] = {13'h1FFF, 13'h1FFD, 13'h1FFD};
        exp_n13[4] = {13'h0001, 13'h1554, 13'h0FFD};
        exp_n13[5] = '0;

        sched_idx = '{2, 3, 0, 1, 2, 3, 4, 3, 4, 2, 1, 5, 5};
        sched_rst = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        sched_eb  = '{1, 1, 1, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0};

        for (int k = 0; k <= c_N + 1; k++) begin
            @(negedge clk);
            if (k >= 1) begin
                check($sformatf("dut0_out k=%0d", k), out0, rst_at(k-1) ? 45'd0 : exp_se1[idx_at(k-1)]);
                check($sformatf("dut1_out k=%0d", k), out1, rst_at(k-1) ? 45'd0 : exp_se0[idx_at(k-1)]);
                check($sformatf("dut3_out k=%0d", k), out3, rst_at(k-1) ? 39'd0 : exp_n13[idx_at(k-1)]);
                check($sformatf("dut0_xb k=%0d", k), xb0, 1'b0);
            end
            if (k >= 2) begin
                check($sformatf("dut2_out k=%0d", k), out2,
                      (rst_at(k-2) || rst_at(k-1)) ? 45'd0 : exp_se1[idx_at(k-2)]);
                check($sformatf("dut2_xb k=%0d", k), xb2,
                      (rst_at(k-2) || rst_at(k-1)) ? 1'b0 : eb_at(k-2));
            end
            in_words     = vin[idx_at(k)];
            rst          = rst_at(k);
            extra_bit_in = eb_at(k);
            #1;
            check($sformatf("dut4_out k=%0d", k), out4, exp_se1[idx_at(k)]);
            check($sformatf("dut4_xb k=%0d", k), xb4, eb_at(k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
